// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive control path.
//   rx_state_t        : receive FSM states
//   err_code_t        : classified error cause reported on err_code
//   DEFAULT_SYNC_BYTE : sync pattern used when the instance does not override it
package rx_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSync,
        StPid,
        StWait,
        StRcv,
        StWrite,
        StDone,
        StEop,
        StErr,
        StEeop,
        StEidle
    } rx_state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_SYNC  = 3'd1,
        ERR_BAD_PID   = 3'd2,
        ERR_OVERFLOW  = 3'd3,
        ERR_FIFO_FULL = 3'd4,
        ERR_EARLY_EOP = 3'd5
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/rx_byte_counter.sv
// Saturating payload byte counter.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : force count to zero (wins over increment)
//   increment  : add one unless already at MAX_BYTES
//   count      : current count
//   at_max     : count equals MAX_BYTES
module rx_byte_counter #(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             increment,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q, count_d;

    assign at_max = (count_q == CNT_W'(MAX_BYTES));
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_pkt_ctrl.sv
// Receive control unit: validates SYNC, checks/captures PID, gates payload
// writes into the RX FIFO, counts payload bytes and classifies errors.
//   clk, n_rst    : clock, asynchronous active-low reset
//   d_edge        : line transition detected
//   eop           : end-of-packet line state present
//   shift_enable  : bit-sample strobe
//   rcv_data      : last fully shifted byte
//   byte_received : one-cycle pulse, rcv_data holds a new byte
//   fifo_full     : RX FIFO cannot accept a write
//   rcving        : packet reception in progress
//   w_enable      : one-cycle FIFO write strobe
//   r_error       : receive error flag
//   err_code      : cause of the first error in the current packet
//   pid/pid_valid : captured PID nibble and its validity
//   byte_count    : payload bytes written in the current packet
//   pkt_done      : one-cycle pulse on clean packet end
module rx_pkt_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(DEFAULT_SYNC_BYTE),
    parameter int unsigned       MAX_BYTES = 64,
    parameter int unsigned       CNT_W     = $clog2(MAX_BYTES + 1),
    parameter bit                CHECK_PID = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_edge,
    input  logic              eop,
    input  logic              shift_enable,
    input  logic [DATA_W-1:0] rcv_data,
    input  logic              byte_received,
    input  logic              fifo_full,
    output logic              rcving,
    output logic              w_enable,
    output logic              r_error,
    output err_code_t         err_code,
    output logic [3:0]        pid,
    output logic              pid_valid,
    output logic [CNT_W-1:0]  byte_count,
    output logic              pkt_done
);

    rx_state_t state_q, state_d;
    err_code_t err_q, err_d;
    logic [3:0] pid_q;
    logic       pid_valid_q;
    logic       enter_sync;
    logic       pid_load;
    logic       at_max;
    logic       pid_ok;
    logic       line_eop;

    assign pid_ok   = !CHECK_PID || (rcv_data[7:4] == ~rcv_data[3:0]);
    assign line_eop = shift_enable && eop;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        enter_sync = 1'b0;
        pid_load   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (d_edge) begin
                    state_d    = StSync;
                    enter_sync = 1'b1;
                end
            end
            StSync: begin
                if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        state_d = StPid;
                    end else begin
                        state_d = StErr;
                        err_d   = ERR_BAD_SYNC;
                    end
                end
            end
            StPid: begin
                if (byte_received) begin
                    if (pid_ok) begin
                        state_d  = StWait;
                        pid_load = 1'b1;
                    end else begin
                        state_d = StErr;
                        err_d   = ERR_BAD_PID;
                    end
                end else if (line_eop) begin
                    state_d = StEeop;
                    err_d   = ERR_EARLY_EOP;
                end
            end
            StWait: begin
                if (shift_enable) begin
                    state_d = eop ? StDone : StRcv;
                end
            end
            StRcv: begin
                // A completed byte takes priority over a same-cycle EOP.
                if (byte_received) begin
                    if (at_max) begin
                        state_d = StErr;
                        err_d   = ERR_OVERFLOW;
                    end else if (fifo_full) begin
                        state_d = StErr;
                        err_d   = ERR_FIFO_FULL;
                    end else begin
                        state_d = StWrite;
                    end
                end else if (line_eop) begin
                    state_d = StEeop;
                    err_d   = ERR_EARLY_EOP;
                end
            end
            StWrite: state_d = StWait;
            StDone:  state_d = StEop;
            StEop: begin
                if (d_edge) state_d = StIdle;
            end
            StErr: begin
                // Keep the original cause; first error wins.
                if (line_eop) state_d = StEeop;
            end
            StEeop: begin
                if (d_edge) state_d = StEidle;
            end
            StEidle: begin
                if (d_edge) begin
                    state_d    = StSync;
                    enter_sync = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_sync) begin
            err_d = ERR_NONE;
        end
    end

    // Moore outputs decoded from the current state only.
    always_comb begin
        rcving   = 1'b0;
        r_error  = 1'b0;
        w_enable = 1'b0;
        pkt_done = 1'b0;
        case (state_q)
            StSync, StPid, StWait, StRcv, StEop: rcving = 1'b1;
            StWrite: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
            end
            StDone: begin
                rcving   = 1'b1;
                pkt_done = 1'b1;
            end
            StErr, StEeop: begin
                rcving  = 1'b1;
                r_error = 1'b1;
            end
            StEidle: r_error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            err_q       <= ERR_NONE;
            pid_q       <= '0;
            pid_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (enter_sync) begin
                pid_valid_q <= 1'b0;
            end else if (pid_load) begin
                pid_q       <= rcv_data[3:0];
                pid_valid_q <= 1'b1;
            end
        end
    end

    assign err_code  = err_q;
    assign pid       = pid_q;
    assign pid_valid = pid_valid_q;

    rx_byte_counter #(
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) u_byte_counter (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (enter_sync),
        .increment (w_enable),
        .count     (byte_count),
        .at_max    (at_max)
    );

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Directed bench for rx_pkt_ctrl. Three instances share one stimulus stream:
// default parameters, CHECK_PID=0 and MAX_BYTES=4.
module tb_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge, eop, shift_enable, byte_received, fifo_full;
    logic [7:0] rcv_data;

    logic       rcving_a, w_enable_a, r_error_a, pid_valid_a, pkt_done_a;
    logic [2:0] err_code_a;
    logic [3:0] pid_a;
    logic [6:0] byte_count_a;

    logic       rcving_b, w_enable_b, r_error_b, pid_valid_b, pkt_done_b;
    logic [2:0] err_code_b;
    logic [3:0] pid_b;
    logic [6:0] byte_count_b;

    logic       rcving_c, w_enable_c, r_error_c, pid_valid_c, pkt_done_c;
    logic [2:0] err_code_c;
    logic [3:0] pid_c;
    logic [2:0] byte_count_c;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_a = 0;
    int wr_c = 0;
    int rerr_a = 0;
    int base;

    always #5 clk = ~clk;

    rx_pkt_ctrl u_dut_a (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
        .rcv_data(rcv_data), .byte_received(byte_received), .fifo_full(fifo_full),
        .rcving(rcving_a), .w_enable(w_enable_a), .r_error(r_error_a), .err_code(err_code_a),
        .pid(pid_a), .pid_valid(pid_valid_a), .byte_count(byte_count_a), .pkt_done(pkt_done_a)
    );

    rx_pkt_ctrl #(.CHECK_PID(1'b0)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
        .rcv_data(rcv_data), .byte_received(byte_received), .fifo_full(fifo_full),
        .rcving(rcving_b), .w_enable(w_enable_b), .r_error(r_error_b), .err_code(err_code_b),
        .pid(pid_b), .pid_valid(pid_valid_b), .byte_count(byte_count_b), .pkt_done(pkt_done_b)
    );

    rx_pkt_ctrl #(.MAX_BYTES(4)) u_dut_c (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
        .rcv_data(rcv_data), .byte_received(byte_received), .fifo_full(fifo_full),
        .rcving(rcving_c), .w_enable(w_enable_c), .r_error(r_error_c), .err_code(err_code_c),
        .pid(pid_c), .pid_valid(pid_valid_c), .byte_count(byte_count_c), .pkt_done(pkt_done_c)
    );

    always @(posedge clk) begin
        if (w_enable_a) wr_a <= wr_a + 1;
        if (w_enable_c) wr_c <= wr_c + 1;
        if (r_error_a)  rerr_a <= rerr_a + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0; fifo_full = 0;
        rcv_data = 8'h00;
    endtask

    task automatic do_reset();
        clear_inputs();
        n_rst = 0;
        tick();
        tick();
        n_rst = 1;
    endtask

    task automatic give_byte(input logic [7:0] b);
        rcv_data = b; byte_received = 1;
        tick();
        byte_received = 0;
    endtask

    task automatic edge_pulse();
        d_edge = 1;
        tick();
        d_edge = 0;
    endtask

    // WAIT -> RCV -> WRITE -> WAIT for one payload byte.
    task automatic payload(input logic [7:0] b);
        shift_enable = 1;
        tick();
        shift_enable = 0;
        give_byte(b);
        tick();
    endtask

    task automatic start_pkt(input logic [7:0] pid_byte);
        edge_pulse();
        give_byte(8'h80);
        give_byte(pid_byte);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_rcving", {31'd0, rcving_a}, 0);
        check_eq("rst_outs", {w_enable_a, r_error_a, pid_valid_a, pkt_done_a}, 0);
        check_eq("rst_err", {29'd0, err_code_a}, 0);
        check_eq("rst_cnt", {25'd0, byte_count_a}, 0);

        // Clean packet
        base = rerr_a;
        edge_pulse();
        check_eq("sync_rcving", {31'd0, rcving_a}, 1);
        give_byte(8'h80);
        give_byte(8'hD2);
        check_eq("pid", {28'd0, pid_a}, 4'h2);
        check_eq("pid_valid", {31'd0, pid_valid_a}, 1);
        shift_enable = 1;
        tick();
        shift_enable = 0;
        give_byte(8'h11);
        check_eq("wr_latency", {31'd0, w_enable_a}, 1);
        tick();
        check_eq("wr_one_cycle", {31'd0, w_enable_a}, 0);
        check_eq("cnt1", {25'd0, byte_count_a}, 1);
        payload(8'h22);
        payload(8'h33);
        check_eq("cnt3", {25'd0, byte_count_a}, 3);
        check_eq("clean_writes", wr_a, 3);
        shift_enable = 1; eop = 1;
        tick();
        shift_enable = 0;
        check_eq("pkt_done", {31'd0, pkt_done_a}, 1);
        tick();
        check_eq("pkt_done_pulse", {31'd0, pkt_done_a}, 0);
        check_eq("eop_rcving", {31'd0, rcving_a}, 1);
        eop = 0;
        edge_pulse();
        check_eq("idle_rcving", {31'd0, rcving_a}, 0);
        check_eq("pid_hold", {27'd0, pid_valid_a, pid_a}, 5'h12);
        check_eq("no_rerror", rerr_a - base, 0);

        // Bad sync, recovery through EIDLE straight into SYNC
        do_reset();
        edge_pulse();
        give_byte(8'h81);
        check_eq("badsync_rerr", {31'd0, r_error_a}, 1);
        check_eq("badsync_code", {29'd0, err_code_a}, 1);
        shift_enable = 1; eop = 1;
        tick();
        shift_enable = 0; eop = 0;
        check_eq("eeop_code", {29'd0, err_code_a}, 1);
        edge_pulse();
        check_eq("eidle_flags", {30'd0, rcving_a, r_error_a}, 2'b01);
        edge_pulse();
        check_eq("resync_flags", {30'd0, rcving_a, r_error_a}, 2'b10);
        check_eq("resync_code", {29'd0, err_code_a}, 0);

        // Bad PID: rejected with check, accepted without
        do_reset();
        base = wr_a;
        start_pkt(8'hD3);
        check_eq("badpid_code", {29'd0, err_code_a}, 2);
        check_eq("badpid_pv", {31'd0, pid_valid_a}, 0);
        check_eq("nocheck_pid", {27'd0, pid_valid_b, pid_b}, 5'h13);
        check_eq("nocheck_code", {29'd0, err_code_b}, 0);
        tick();
        check_eq("badpid_nowr", wr_a - base, 0);

        // Overflow on the MAX_BYTES=4 instance
        do_reset();
        base = wr_c;
        start_pkt(8'hD2);
        for (int i = 0; i < 4; i++) payload(8'(8'h40 + i));
        check_eq("ovf_cnt4", {29'd0, byte_count_c}, 4);
        shift_enable = 1;
        tick();
        shift_enable = 0;
        give_byte(8'h55);
        check_eq("ovf_code", {29'd0, err_code_c}, 3);
        tick();
        check_eq("ovf_writes", wr_c - base, 4);
        check_eq("ovf_cnt_hold", {29'd0, byte_count_c}, 4);

        // FIFO full at the second payload byte
        do_reset();
        base = wr_a;
        start_pkt(8'hD2);
        payload(8'h01);
        shift_enable = 1;
        tick();
        shift_enable = 0;
        fifo_full = 1;
        give_byte(8'h02);
        fifo_full = 0;
        check_eq("full_code", {29'd0, err_code_a}, 4);
        tick();
        check_eq("full_writes", wr_a - base, 1);

        // EOP inside a byte
        do_reset();
        start_pkt(8'hD2);
        shift_enable = 1;
        tick();
        eop = 1;
        tick();
        shift_enable = 0; eop = 0;
        check_eq("early_code", {29'd0, err_code_a}, 5);
        check_eq("early_flags", {30'd0, rcving_a, r_error_a}, 2'b11);

        // byte_received wins over a same-cycle EOP
        do_reset();
        start_pkt(8'hD2);
        shift_enable = 1;
        tick();
        eop = 1; rcv_data = 8'h77; byte_received = 1;
        tick();
        byte_received = 0; shift_enable = 0; eop = 0;
        check_eq("br_prio_wr", {31'd0, w_enable_a}, 1);
        check_eq("br_prio_code", {29'd0, err_code_a}, 0);

        // Asynchronous reset while waiting after two writes
        do_reset();
        start_pkt(8'hD2);
        payload(8'hA1);
        payload(8'hA2);
        check_eq("pre_rst_cnt", {25'd0, byte_count_a}, 2);
        base = wr_a;
        #2;
        n_rst = 0;
        #1;
        check_eq("async_outs", {24'd0, rcving_a, w_enable_a, r_error_a, pid_valid_a, pkt_done_a,
                                err_code_a}, 0);
        check_eq("async_cnt", {25'd0, byte_count_a}, 0);
        tick();
        n_rst = 1;
        check_eq("async_nowr", wr_a - base, 0);
        start_pkt(8'hD2);
        payload(8'hB0);
        check_eq("after_rst_cnt", {25'd0, byte_count_a}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/rx_pkt_ctrl.md
Name: rx_pkt_ctrl

Overview:
- Parametrised receive control unit for the USB-style serial receiver.
- Sits between the shift register / edge / EOP detectors and the RX FIFO.
- Validates the SYNC byte, then checks and captures the PID byte.
- Gates data-byte writes into the FIFO, counts payload bytes, and reports a classified error code and a packet-done pulse.

Parameters:
- DATA_W, 8: width of rcv_data.
- SYNC_BYTE, 8'h80: expected sync pattern; width DATA_W.
- MAX_BYTES, 64: maximum payload bytes accepted after the PID.
- CNT_W, $clog2(MAX_BYTES+1): byte counter width.
- CHECK_PID, 1: 1 = enforce PID check rcv_data[7:4] == ~rcv_data[3:0]; 0 = accept any PID.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- d_edge  in  1  line transition detected
- eop  in  1  end-of-packet line state present
- shift_enable  in  1  bit-sample strobe
- rcv_data  in  DATA_W  last fully shifted byte
- byte_received  in  1  one-cycle pulse: rcv_data holds a new byte
- fifo_full  in  1  RX FIFO cannot accept a write
- rcving  out  1  packet reception in progress
- w_enable  out  1  one-cycle FIFO write strobe
- r_error  out  1  receive error flag
- err_code  out  3  cause of last error (package enum)
- pid  out  4  captured PID, rcv_data[3:0] of the PID byte
- pid_valid  out  1  pid holds a checked PID for the current packet
- byte_count  out  CNT_W  payload bytes written in the current packet
- pkt_done  out  1  one-cycle pulse: packet ended cleanly

Behaviour:
- Reset: clk domain only; n_rst is asynchronous, active-low. State = IDLE. All outputs 0, err_code = ERR_NONE. Reset mid-packet aborts the packet with no write.
- State machine is Moore on outputs. States: IDLE, SYNC, PID, WAIT, RCV, WRITE, DONE, EOP, ERR, EEOP, EIDLE.
- IDLE: d_edge -> SYNC.
- Entry to SYNC (from IDLE or EIDLE):
  - clears byte_count, pid_valid and err_code.
  - r_error drops in SYNC.
- SYNC:
  - byte_received & rcv_data==SYNC_BYTE -> PID.
  - byte_received & mismatch -> ERR, code ERR_BAD_SYNC.
- PID, on byte_received:
  - CHECK_PID & nibble check fails -> ERR, code ERR_BAD_PID.
  - otherwise latch pid, set pid_valid=1 -> WAIT.
  - The PID byte is never written to the FIFO.
- PID, no byte_received: shift_enable & eop -> EEOP, code ERR_EARLY_EOP.
- WAIT:
  - shift_enable & eop -> DONE.
  - shift_enable & !eop -> RCV.
- RCV, on byte_received (byte_received has priority over eop in the same cycle):
  - byte_count==MAX_BYTES -> ERR, code ERR_OVERFLOW.
  - else fifo_full -> ERR, code ERR_FIFO_FULL.
  - else -> WRITE.
- RCV, no byte_received: shift_enable & eop -> EEOP, code ERR_EARLY_EOP.
- WRITE:
  - w_enable=1 for exactly this cycle; byte_count increments (registered, visible next cycle).
  - -> WAIT unconditionally.
  - Write latency: one cycle after the byte_received pulse.
- DONE: pkt_done=1 for one cycle -> EOP unconditionally.
- EOP: d_edge -> IDLE.
- ERR: shift_enable & eop -> EEOP.
- EEOP: d_edge -> EIDLE.
- EIDLE: d_edge -> SYNC. A new packet starts after an error with no pass through IDLE.
- First error wins: err_code is written only on entry to ERR, or on entry to EEOP from PID/RCV. ERR->EEOP keeps the existing code.
- Outputs by state:
  - rcving=1 in SYNC, PID, WAIT, RCV, WRITE, DONE, EOP, ERR, EEOP.
  - r_error=1 in ERR, EEOP, EIDLE.
- pid and pid_valid hold after the packet until the next SYNC entry.
- byte_count saturates at MAX_BYTES and never wraps.
- An unreachable state encoding returns to IDLE.

Decomposition:
- Package rx_ctrl_pkg:
  - rx_state_t enum.
  - err_code_t enum: ERR_NONE=0, ERR_BAD_SYNC=1, ERR_BAD_PID=2, ERR_OVERFLOW=3, ERR_FIFO_FULL=4, ERR_EARLY_EOP=5.
  - Default SYNC_BYTE constant.
- Sub-module rx_byte_counter:
  - Inputs: clear, increment, saturating at MAX_BYTES.
  - Output: count, plus at_max flag.

Test Plan:
- Clean packet: SYNC 8'h80, PID 8'hD2, payload 8'h11/8'h22/8'h33, then eop -> 3 w_enable pulses each 1 cycle after byte_received; pid=4'h2, pid_valid=1; byte_count=3; pkt_done one pulse; IDLE after d_edge; r_error never 1.
- Bad sync 8'h81 -> ERR, r_error=1, err_code=1. Then eop and two d_edges -> EIDLE, then SYNC; r_error clears and err_code=0.
- Bad PID 8'hD3 with CHECK_PID=1 -> err_code=2, no w_enable. Same byte with CHECK_PID=0 -> pid=4'h3 accepted.
- MAX_BYTES=4, 5 payload bytes -> 4 writes; 5th byte gives err_code=3, byte_count holds 4. fifo_full=1 at byte 2 -> err_code=4, 1 write total.
- eop during RCV mid-byte -> EEOP, err_code=5, rcving=1, r_error=1. byte_received with eop in the same cycle -> WRITE taken first.
- n_rst low during WAIT after 2 writes -> all outputs 0 immediately, no write; next packet counts from 0.
